// File: rtl/param_register_file_if.sv
// rtl/param_register_file_if.sv - register file access bundle (write port, two read ports, clear/status)
interface param_register_file_if #(
   parameter int WIDTH_OF_REGISTER = 16,
   parameter int WIDTH_OF_ADDR     = 3
);
   logic                         enable;
   logic                         wr_en;
   logic [WIDTH_OF_ADDR-1:0]     rd_adrs;
   logic [WIDTH_OF_REGISTER-1:0] data_in;
   logic [WIDTH_OF_ADDR-1:0]     ra_adrs;
   logic [WIDTH_OF_ADDR-1:0]     rb_adrs;
   logic                         clear;
   logic [WIDTH_OF_REGISTER-1:0] ra_out;
   logic [WIDTH_OF_REGISTER-1:0] rb_out;
   logic                         busy;
   logic                         clear_done;

   modport master (
      output enable, wr_en, rd_adrs, data_in, ra_adrs, rb_adrs, clear,
      input  ra_out, rb_out, busy, clear_done
   );

   modport slave (
      input  enable, wr_en, rd_adrs, data_in, ra_adrs, rb_adrs, clear,
      output ra_out, rb_out, busy, clear_done
   );
endinterface

// File: rtl/param_register_file.sv
// rtl/param_register_file.sv - parametrised register file, 1 write / 2 registered read ports, sequenced clear
module param_register_file #(
   parameter int NUM_OF_REGISTER   = 8,
   parameter int WIDTH_OF_REGISTER = 16,
   parameter int WIDTH_OF_ADDR     = 3,
   parameter int ZERO_REG          = 0
) (
   input  logic                  clock,
   input  logic                  reset_n,
   param_register_file_if.slave  bus
);
   typedef enum logic {IDLE, CLEAR} state_t;

   localparam logic [WIDTH_OF_ADDR:0]   NUM_W = NUM_OF_REGISTER[WIDTH_OF_ADDR:0];
   localparam logic [WIDTH_OF_ADDR-1:0] LAST  = WIDTH_OF_ADDR'(NUM_OF_REGISTER - 1);

   state_t                         state, state_next;
   logic [WIDTH_OF_ADDR-1:0]       idx, idx_next;
   logic [WIDTH_OF_REGISTER-1:0]   regs [NUM_OF_REGISTER];
   logic                           wr_accept;
   logic [WIDTH_OF_REGISTER-1:0]   ra_val, rb_val;

   function automatic logic addr_ok(input logic [WIDTH_OF_ADDR-1:0] a);
      return ({1'b0, a} < NUM_W) && !((ZERO_REG != 0) && (a == '0));
   endfunction

   // Read value as seen after this edge: write bypass first, then the clear sweep.
   function automatic logic [WIDTH_OF_REGISTER-1:0] value(input logic [WIDTH_OF_ADDR-1:0] a);
      if (!addr_ok(a))                    return '0;
      if (wr_accept && a == bus.rd_adrs)  return bus.data_in;
      if (state == CLEAR && a == idx)     return '0;
      return regs[a];
   endfunction

   always_comb begin
      state_next = state;
      idx_next   = idx;
      case (state)
         IDLE: begin
            if (bus.clear) begin
               state_next = CLEAR;
               idx_next   = '0;
            end
         end
         CLEAR: begin
            if (idx == LAST) state_next = IDLE;
            else             idx_next   = idx + 1'b1;
         end
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      wr_accept = bus.enable && bus.wr_en && (state == IDLE) && !bus.clear && addr_ok(bus.rd_adrs);
      ra_val    = value(bus.ra_adrs);
      rb_val    = value(bus.rb_adrs);
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
         idx   <= '0;
      end else begin
         state <= state_next;
         idx   <= idx_next;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NUM_OF_REGISTER; i++) regs[i] <= '0;
      end else if (state == CLEAR) begin
         regs[idx] <= '0;
      end else if (wr_accept) begin
         regs[bus.rd_adrs] <= bus.data_in;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         bus.ra_out     <= '0;
         bus.rb_out     <= '0;
         bus.busy       <= 1'b0;
         bus.clear_done <= 1'b0;
      end else begin
         if (bus.enable) begin
            bus.ra_out <= ra_val;
            bus.rb_out <= rb_val;
         end
         bus.busy       <= (state_next == CLEAR);
         bus.clear_done <= (state == CLEAR) && (idx == LAST);
      end
   end
endmodule

// File: tb/tb_param_register_file.sv
// tb/tb_param_register_file.sv - self-checking bench for param_register_file (8-reg and 6-reg/zero-reg instances)
module tb_param_register_file;
   localparam int W = 16;
   localparam int A = 3;

   logic clock = 1'b0;
   logic reset_n = 1'b0;
   always #5 clock = ~clock;

   logic         en, wr, clr;
   logic [A-1:0] wadr, ra, rb;
   logic [W-1:0] din;

   param_register_file_if #(.WIDTH_OF_REGISTER(W), .WIDTH_OF_ADDR(A)) bus0 ();
   param_register_file_if #(.WIDTH_OF_REGISTER(W), .WIDTH_OF_ADDR(A)) bus1 ();

   assign bus0.enable = en;  assign bus1.enable = en;
   assign bus0.wr_en = wr;   assign bus1.wr_en = wr;
   assign bus0.rd_adrs = wadr; assign bus1.rd_adrs = wadr;
   assign bus0.data_in = din;  assign bus1.data_in = din;
   assign bus0.ra_adrs = ra;   assign bus1.ra_adrs = ra;
   assign bus0.rb_adrs = rb;   assign bus1.rb_adrs = rb;
   assign bus0.clear = clr;    assign bus1.clear = clr;

   param_register_file #(.NUM_OF_REGISTER(8), .WIDTH_OF_REGISTER(W), .WIDTH_OF_ADDR(A), .ZERO_REG(0))
      dut0 (.clock(clock), .reset_n(reset_n), .bus(bus0));
   param_register_file #(.NUM_OF_REGISTER(6), .WIDTH_OF_REGISTER(W), .WIDTH_OF_ADDR(A), .ZERO_REG(1))
      dut1 (.clock(clock), .reset_n(reset_n), .bus(bus1));

   int checks = 0;
   int errors = 0;

   // Reference model: index 0 = 8 regs, plain; index 1 = 6 regs, register 0 hard-wired to zero.
   int           nreg [2] = '{8, 6};
   bit           zr   [2] = '{1'b0, 1'b1};
   logic [W-1:0] mreg [2][8];
   logic [W-1:0] mra  [2];
   logic [W-1:0] mrb  [2];
   bit           mbusy[2], mdone[2], mcl[2];
   int           midx [2];

   task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         for (int i = 0; i < 8; i++) mreg[k][i] = '0;
         mra[k] = '0; mrb[k] = '0;
         mbusy[k] = 0; mdone[k] = 0; mcl[k] = 0; midx[k] = 0;
      end
   endtask

   function automatic logic [W-1:0] mval(input int k, input int a, input bit acc);
      if (a >= nreg[k] || (zr[k] && a == 0)) return '0;
      if (acc && a == int'(wadr))            return din;
      if (mcl[k] && a == midx[k])            return '0;
      return mreg[k][a];
   endfunction

   task automatic model_edge();
      bit acc;
      logic [W-1:0] va, vb;
      for (int k = 0; k < 2; k++) begin
         acc = en && wr && !mcl[k] && !clr && (int'(wadr) < nreg[k]) && !(zr[k] && wadr == 0);
         va = mval(k, int'(ra), acc);
         vb = mval(k, int'(rb), acc);
         if (en) begin
            mra[k] = va;
            mrb[k] = vb;
         end
         mdone[k] = 0;
         if (mcl[k]) begin
            mreg[k][midx[k]] = '0;
            if (midx[k] == nreg[k] - 1) begin
               mcl[k] = 0;
               mdone[k] = 1;
            end else begin
               midx[k]++;
            end
         end else if (clr) begin
            mcl[k] = 1;
            midx[k] = 0;
         end else if (acc) begin
            mreg[k][wadr] = din;
         end
         mbusy[k] = mcl[k];
      end
   endtask

   task automatic check_all(input string tag);
      check($sformatf("%s_ra0", tag), bus0.ra_out, mra[0]);
      check($sformatf("%s_rb0", tag), bus0.rb_out, mrb[0]);
      check($sformatf("%s_busy0", tag), W'(bus0.busy), W'(mbusy[0]));
      check($sformatf("%s_done0", tag), W'(bus0.clear_done), W'(mdone[0]));
      check($sformatf("%s_ra1", tag), bus1.ra_out, mra[1]);
      check($sformatf("%s_rb1", tag), bus1.rb_out, mrb[1]);
      check($sformatf("%s_busy1", tag), W'(bus1.busy), W'(mbusy[1]));
      check($sformatf("%s_done1", tag), W'(bus1.clear_done), W'(mdone[1]));
   endtask

   task automatic cycle(input string tag);
      @(posedge clock);
      model_edge();
      @(negedge clock);
      check_all(tag);
   endtask

   initial begin
      en = 0; wr = 0; clr = 0; wadr = 0; ra = 0; rb = 0; din = 0;
      model_reset();
      @(negedge clock);
      @(negedge clock);
      check_all("reset");
      reset_n = 1'b1;
      #1 check_all("release");
      @(negedge clock);

      en = 1; wr = 1;
      for (int i = 0; i < 8; i++) begin
         wadr = A'(i); din = W'(32 - i);
         cycle("load");
      end

      wr = 0;
      for (int i = 0; i < 4; i++) begin
         ra = A'(i); rb = A'(i + 4);
         cycle("read");
         check("tp_ra", bus0.ra_out, W'(32 - i));
         check("tp_rb", bus0.rb_out, W'(28 - i));
      end

      wr = 1; wadr = 5; din = 16'hBEEF; ra = 5;
      cycle("bypass");
      check("bypass_ra", bus0.ra_out, 16'hBEEF);
      en = 0; wr = 0; ra = 1;
      cycle("hold");
      check("hold_ra", bus0.ra_out, 16'hBEEF);
      en = 1;

      wr = 1; wadr = 0; din = 16'h1234; ra = 0;
      cycle("zero");
      check("zero_reg_ra", bus1.ra_out, 16'h0000);
      check("zero_plain_ra", bus0.ra_out, 16'h1234);
      wadr = 7; din = 16'h7777; rb = 7;
      cycle("range");
      check("range_rb", bus1.rb_out, 16'h0000);
      check("range_plain_rb", bus0.rb_out, 16'h7777);

      for (int i = 0; i < 8; i++) begin
         wadr = A'(i); din = W'($urandom) | W'(1);
         cycle("fill");
      end

      clr = 1; wr = 1; wadr = 3; din = 16'h5555; ra = 3; rb = 3;
      cycle("clr_start");
      check("clr_busy", W'(bus0.busy), W'(1));
      clr = 0;
      for (int c = 1; c <= 8; c++) begin
         wr = (c == 8); wadr = 2; din = 16'hABCD;
         cycle("clr_run");
         check("clr_busy_seq", W'(bus0.busy), W'(c < 8));
         check("clr_done_seq", W'(bus0.clear_done), W'(c == 8));
      end
      wr = 1; wadr = 4; din = 16'h4444; ra = 4;
      cycle("post_clr_wr");
      check("post_clr_wr", bus0.ra_out, 16'h4444);
      wr = 0;
      for (int i = 0; i < 8; i++) begin
         ra = A'(i); rb = A'(i);
         cycle("post_clr_rd");
         check("post_clr_rd", bus0.ra_out, (i == 4) ? 16'h4444 : 16'h0000);
      end

      clr = 1;
      cycle("reclr_start");
      clr = 0;
      for (int c = 1; c <= 8; c++) begin
         clr = (c == 3);
         cycle("reclr_run");
         check("reclr_done", W'(bus0.clear_done), W'(c == 8));
      end
      clr = 0;
      cycle("reclr_after");

      clr = 1;
      cycle("rst_clr_start");
      clr = 0;
      for (int c = 0; c < 3; c++) cycle("rst_clr_run");
      #2 reset_n = 1'b0;
      #1 model_reset();
      check_all("async_rst");
      @(posedge clock);
      @(negedge clock);
      reset_n = 1'b1;
      check_all("rst_hold");
      wr = 1; wadr = 6; din = 16'h6060; ra = 6;
      cycle("rst_idle_wr");
      check("rst_idle_wr", bus0.ra_out, 16'h6060);

      wadr = 2; din = 16'h2222; ra = 2; rb = 2;
      cycle("same_addr");
      check("same_ra", bus0.ra_out, 16'h2222);
      check("same_rb", bus0.rb_out, 16'h2222);

      for (int n = 0; n < 400; n++) begin
         en   = ($urandom_range(0, 7) != 0);
         wr   = ($urandom_range(0, 1) != 0);
         wadr = A'($urandom_range(0, 7));
         ra   = A'($urandom_range(0, 7));
         rb   = A'($urandom_range(0, 7));
         din  = W'($urandom);
         clr  = ($urandom_range(0, 31) == 0);
         cycle("rand");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
